// File: rtl/calc_entry_fmt.sv
// Calculator entry formatter: debounces the push button, captures the operands,
// computes the signed result, converts it to BCD and strobes one display line.
module calc_entry_fmt #(
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
   parameter int unsigned SETUP_CYCLES    = 32'd2,
   parameter int unsigned ENTER_CYCLES    = 32'd4
) (
   input  logic       CLOCK_50,
   input  logic       ar,
   input  logic       go_n,
   input  logic [3:0] a_mag,
   input  logic       a_neg,
   input  logic [3:0] b_mag,
   input  logic       b_neg,
   input  logic [1:0] op_sel,
   output logic [3:0] x_in4,
   output logic [3:0] x_in1,
   output logic [3:0] x_in2,
   output logic [3:0] x_in3,
   output logic       aSign,
   output logic       bSign,
   output logic       bothSign,
   output logic [3:0] Op,
   output logic       enter,
   output logic       busy,
   output logic [1:0] entry_cnt
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CALC    = 3'd1,
      S_CONV    = 3'd2,
      S_PRESENT = 3'd3,
      S_STROBE  = 3'd4,
      S_RELEASE = 3'd5
   } state_t;

   localparam logic [7:0] CONV_LAST  = 8'd6;
   localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 32'd1);
   localparam logic [7:0] ENTER_LAST = 8'(ENTER_CYCLES - 32'd1);

   state_t             state_r;
   state_t             state_nxt_s;
   logic [7:0]         cyc_r;

   logic               sync1_r;
   logic               sync2_r;
   logic               deb_r;
   logic               deb_d_r;
   logic [19:0]        deb_cnt_r;
   logic               press_s;

   logic [3:0]         a_mag_r;
   logic               a_neg_r;
   logic [3:0]         b_mag_r;
   logic               b_neg_r;
   logic [1:0]         op_r;

   logic signed [7:0]  sa_s;
   logic signed [7:0]  sb_s;
   logic signed [7:0]  res_s;
   logic [6:0]         mag_s;
   logic [14:0]        conv_r;
   logic [14:0]        conv_fin_s;
   logic               neg_r;

   function automatic logic [3:0] clamp9(input logic [3:0] m);
      return (m > 4'd9) ? 4'd9 : m;
   endfunction

   // One double-dabble step on {tens, units, binary}: adjust nibbles >= 5, then shift.
   function automatic logic [14:0] dabble_step(input logic [14:0] v);
      logic [14:0] t;
      t        = v;
      t[14:11] = (v[14:11] >= 4'd5) ? v[14:11] + 4'd3 : v[14:11];
      t[10:7]  = (v[10:7]  >= 4'd5) ? v[10:7]  + 4'd3 : v[10:7];
      return {t[13:0], 1'b0};
   endfunction

   // Button synchronizer and debouncer; a level differing from the debounced one
   // restarts counting from zero each time it reappears.
   always_ff @(posedge CLOCK_50 or posedge ar) begin
      if (ar) begin
         sync1_r   <= 1'b1;
         sync2_r   <= 1'b1;
         deb_r     <= 1'b1;
         deb_d_r   <= 1'b1;
         deb_cnt_r <= 20'd0;
      end else begin
         sync1_r <= go_n;
         sync2_r <= sync1_r;
         deb_d_r <= deb_r;
         if (sync2_r != deb_r) begin
            if (deb_cnt_r == DEBOUNCE_CYCLES - 20'd1) begin
               deb_r     <= sync2_r;
               deb_cnt_r <= 20'd0;
            end else begin
               deb_cnt_r <= deb_cnt_r + 20'd1;
            end
         end else begin
            deb_cnt_r <= 20'd0;
         end
      end
   end

   assign press_s = deb_d_r & ~deb_r;

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE:    state_nxt_s = press_s ? S_CALC : S_IDLE;
         S_CALC:    state_nxt_s = S_CONV;
         S_CONV:    state_nxt_s = (cyc_r == CONV_LAST) ? S_PRESENT : S_CONV;
         S_PRESENT: state_nxt_s = (cyc_r == SETUP_LAST) ? S_STROBE : S_PRESENT;
         S_STROBE:  state_nxt_s = (cyc_r == ENTER_LAST) ? S_RELEASE : S_STROBE;
         S_RELEASE: state_nxt_s = deb_r ? S_IDLE : S_RELEASE;
         default:   state_nxt_s = S_IDLE;
      endcase
   end

   // Signed arithmetic on the captured operands; |r| <= 81 fits in 7 bits.
   always_comb begin
      sa_s = a_neg_r ? (8'd0 - {4'd0, a_mag_r}) : {4'd0, a_mag_r};
      sb_s = b_neg_r ? (8'd0 - {4'd0, b_mag_r}) : {4'd0, b_mag_r};
      case (op_r)
         2'b00:   res_s = sa_s - sb_s;
         2'b01:   res_s = sa_s + sb_s;
         default: res_s = sa_s * sb_s;
      endcase
      mag_s      = res_s[7] ? 7'(8'd0 - res_s) : res_s[6:0];
      conv_fin_s = dabble_step(conv_r);
   end

   // State register, phase counter, capture/convert datapath and registered outputs.
   always_ff @(posedge CLOCK_50 or posedge ar) begin
      if (ar) begin
         state_r   <= S_IDLE;
         cyc_r     <= 8'd0;
         a_mag_r   <= 4'd0;
         a_neg_r   <= 1'b0;
         b_mag_r   <= 4'd0;
         b_neg_r   <= 1'b0;
         op_r      <= 2'b00;
         conv_r    <= 15'd0;
         neg_r     <= 1'b0;
         x_in4     <= 4'd0;
         x_in1     <= 4'd0;
         x_in2     <= 4'd0;
         x_in3     <= 4'd0;
         aSign     <= 1'b0;
         bSign     <= 1'b0;
         bothSign  <= 1'b0;
         Op        <= 4'd0;
         enter     <= 1'b0;
         busy      <= 1'b0;
         entry_cnt <= 2'd0;
      end else begin
         state_r <= state_nxt_s;
         if (state_nxt_s != state_r) begin
            cyc_r <= 8'd0;
         end else begin
            cyc_r <= cyc_r + 8'd1;
         end
         enter <= (state_nxt_s == S_STROBE);
         busy  <= (state_nxt_s != S_IDLE);
         case (state_r)
            S_IDLE: begin
               if (press_s) begin
                  a_mag_r <= clamp9(a_mag);
                  a_neg_r <= a_neg;
                  b_mag_r <= clamp9(b_mag);
                  b_neg_r <= b_neg;
                  op_r    <= (op_sel == 2'b11) ? 2'b10 : op_sel;
               end
            end
            S_CALC: begin
               conv_r <= {8'd0, mag_s};
               neg_r  <= res_s[7];
            end
            S_CONV: begin
               conv_r <= conv_fin_s;
               // The seventh shift lands on this same edge, so present the step output.
               if (state_nxt_s == S_PRESENT) begin
                  x_in4    <= a_mag_r;
                  x_in1    <= b_mag_r;
                  x_in2    <= conv_fin_s[14:11];
                  x_in3    <= conv_fin_s[10:7];
                  aSign    <= a_neg_r;
                  bSign    <= b_neg_r;
                  bothSign <= neg_r;
                  Op       <= {2'b00, op_r};
               end
            end
            S_STROBE: begin
               if (state_nxt_s == S_RELEASE) begin
                  entry_cnt <= entry_cnt + 2'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_calc_entry_fmt.sv
// Self-checking bench for calc_entry_fmt: directed plan cases plus randomized
// entries compared against an arithmetic reference model.
module tb_calc_entry_fmt;

   localparam int DEB = 16;
   // go_n low sampled on edge 1 -> 2 sync edges + DEB debounce edges + 1 edge to
   // sample press_pulse + 10 clocks to enter.
   localparam int LAT = 2 + DEB + 1 + 10;

   logic       clk = 1'b0;
   logic       ar = 1'b1;
   logic       go_n = 1'b1;
   logic [3:0] a_mag = 4'd0;
   logic       a_neg = 1'b0;
   logic [3:0] b_mag = 4'd0;
   logic       b_neg = 1'b0;
   logic [1:0] op_sel = 2'b00;
   logic [3:0] x_in4, x_in1, x_in2, x_in3, Op;
   logic       aSign, bSign, bothSign, enter, busy;
   logic [1:0] entry_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_cnt = 0;
   logic [22:0] prev_pack = 23'd0;

   logic [22:0] data_s;
   logic [26:0] all_s;
   assign data_s = {x_in4, x_in1, x_in2, x_in3, aSign, bSign, bothSign, Op};
   assign all_s  = {data_s, enter, busy, entry_cnt};

   calc_entry_fmt #(.DEBOUNCE_CYCLES(20'd16), .SETUP_CYCLES(32'd2), .ENTER_CYCLES(32'd4)) dut (
      .CLOCK_50(clk), .ar(ar), .go_n(go_n),
      .a_mag(a_mag), .a_neg(a_neg), .b_mag(b_mag), .b_neg(b_neg), .op_sel(op_sel),
      .x_in4(x_in4), .x_in1(x_in1), .x_in2(x_in2), .x_in3(x_in3),
      .aSign(aSign), .bSign(bSign), .bothSign(bothSign), .Op(Op),
      .enter(enter), .busy(busy), .entry_cnt(entry_cnt)
   );

   always #10 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected display fields straight from the arithmetic rules.
   function automatic logic [22:0] model(input int a, input int an, input int b, input int bn, input int op);
      int am, bm, sa, sb, r, mag;
      logic [3:0] opc;
      am  = (a > 9) ? 9 : a;
      bm  = (b > 9) ? 9 : b;
      sa  = (an != 0) ? -am : am;
      sb  = (bn != 0) ? -bm : bm;
      if (op == 0)      r = sa - sb;
      else if (op == 1) r = sa + sb;
      else              r = sa * sb;
      mag = (r < 0) ? -r : r;
      opc = (op == 3) ? 4'd2 : 4'(op);
      return {4'(am), 4'(bm), 4'(mag / 10), 4'(mag % 10),
              1'(an), 1'(bn), (r < 0), opc};
   endfunction

   // Press and hold the button; checks latency, data, strobe width and count.
   task automatic do_entry(input int a, input int an, input int b, input int bn, input int op);
      logic [22:0] exp;
      int rise, w;
      exp = model(a, an, b, bn, op);
      @(negedge clk);
      a_mag = 4'(a); a_neg = 1'(an); b_mag = 4'(b); b_neg = 1'(bn); op_sel = 2'(op);
      go_n = 1'b0;
      rise = 0;
      for (int i = 1; i <= LAT + 20; i++) begin
         @(negedge clk);
         if (i == LAT - 4) check_eq("hold_prev", 32'(data_s), 32'(prev_pack));
         if (enter && rise == 0) begin
            rise = i;
            break;
         end
      end
      check_eq("latency", 32'(rise), 32'(LAT));
      check_eq("data", 32'(data_s), 32'(exp));
      a_mag = 4'($urandom_range(0, 15)); a_neg = 1'($urandom_range(0, 1));
      b_mag = 4'($urandom_range(0, 15)); b_neg = 1'($urandom_range(0, 1));
      op_sel = 2'($urandom_range(0, 3));
      w = 1;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (!enter) break;
         w++;
      end
      check_eq("enter_width", 32'(w), 32'd4);
      exp_cnt = (exp_cnt + 1) % 4;
      check_eq("entry_cnt", 32'(entry_cnt), 32'(exp_cnt));
      check_eq("busy_held", 32'(busy), 32'd1);
      prev_pack = exp;
   endtask

   task automatic release_btn();
      go_n = 1'b1;
      repeat (DEB + 10) @(negedge clk);
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("data_stable", 32'(data_s), 32'(prev_pack));
   endtask

   task automatic count_enters(input int cycles, output int n);
      logic last;
      n = 0;
      last = enter;
      repeat (cycles) begin
         @(negedge clk);
         if (enter && !last) n++;
         last = enter;
      end
   endtask

   task automatic reset_at(input int cyc, input string tag);
      int n;
      @(negedge clk);
      a_mag = 4'd6; a_neg = 1'b1; b_mag = 4'd7; b_neg = 1'b0; op_sel = 2'b10;
      go_n = 1'b0;
      repeat (cyc) @(negedge clk);
      check_eq({tag, "_busy"}, 32'(busy), 32'd1);
      ar = 1'b1;
      #1;
      check_eq({tag, "_zero"}, 32'(all_s), 32'd0);
      repeat (2) @(negedge clk);
      go_n = 1'b1;
      ar = 1'b0;
      count_enters(LAT + 10, n);
      check_eq({tag, "_no_enter"}, 32'(n), 32'd0);
      check_eq({tag, "_cnt"}, 32'(entry_cnt), 32'd0);
      exp_cnt = 0;
      prev_pack = 23'd0;
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check_eq("reset_state", 32'(all_s), 32'd0);
      ar = 1'b0;
      repeat (3) @(negedge clk);

      do_entry(7, 0, 8, 1, 2);
      release_btn();
      do_entry(3, 0, 5, 0, 0);
      release_btn();
      do_entry(4, 1, 4, 0, 1);
      release_btn();
      do_entry(12, 0, 9, 0, 3);
      release_btn();
      do_entry(0, 1, 5, 1, 2);
      release_btn();

      // Bounces shorter than the debounce window never produce an entry.
      for (int k = 0; k < 16; k++) begin
         go_n = ~go_n;
         repeat ($urandom_range(1, DEB - 4)) @(negedge clk);
      end
      go_n = 1'b1;
      count_enters(DEB + 10, n);
      check_eq("bounce_enter", 32'(n), 32'd0);
      check_eq("bounce_busy", 32'(busy), 32'd0);

      do_entry(2, 0, 9, 1, 1);
      count_enters(1000, n);
      check_eq("hold_no_repeat", 32'(n), 32'd0);
      release_btn();

      reset_at(LAT - 5, "rst_conv");
      reset_at(LAT + 1, "rst_strobe");
      do_entry(7, 0, 8, 1, 2);
      release_btn();

      for (int k = 0; k < 12; k++) begin
         do_entry($urandom_range(0, 15), $urandom_range(0, 1),
                  $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 3));
         release_btn();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #20_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
